// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with a 2-entry skid buffer, synchronous flush,
// bubble-forced control output and a saturating stall counter.
module pipe_stage_skid #(
    parameter int                CTRL_W      = 24,
    parameter int                DATA_W      = 128,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
    parameter int                STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [DATA_W-1:0]      out_data,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    // Encoding is {skid_valid, out_valid}; 2'b10 cannot be reached.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;
    localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    state_t                   state_q, state_d;
    logic [CTRL_W-1:0]        main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]        main_data_q, main_data_d;
    logic [CTRL_W-1:0]        skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0]        skid_data_q, skid_data_d;
    logic [STALL_CNT_W-1:0]   stall_q, stall_d;

    logic skid_valid;
    logic in_fire;
    logic out_fire;

    assign skid_valid = state_q[1];
    assign out_valid  = state_q[0];
    // Ready comes straight from a register so out_ready never reaches in_ready.
    assign in_ready   = ~skid_valid;
    assign in_fire    = in_valid & in_ready;
    assign out_fire   = out_valid & out_ready;

    assign out_ctrl     = main_ctrl_q;
    assign out_data     = main_data_q;
    assign occupancy    = {1'b0, out_valid} + {1'b0, skid_valid};
    assign stall_cycles = stall_q;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            // Data registers are left alone; only validity and control squash.
            state_d     = ST_EMPTY;
            main_ctrl_d = CTRL_BUBBLE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && !out_fire) begin
                        state_d     = ST_FULL;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (in_fire && out_fire) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (out_fire) begin
                        state_d     = ST_EMPTY;
                        main_ctrl_d = CTRL_BUBBLE;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d     = ST_ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    main_ctrl_d = CTRL_BUBBLE;
                end
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + STALL_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_ctrl_q <= CTRL_BUBBLE;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            stall_q     <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus random traffic checked
// against a queue-based reference model.
module tb_pipe_stage_skid;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [23:0]  in_ctrl;
    logic [127:0] in_data;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [23:0]  out_ctrl;
    logic [127:0] out_data;
    logic [1:0]   occupancy;
    logic [15:0]  stall_cycles;

    // Second instance with a 3-bit stall counter for saturation checks.
    logic         s_in_valid;
    logic         s_in_ready;
    logic [23:0]  s_out_ctrl;
    logic [127:0] s_out_data;
    logic         s_out_valid;
    logic         s_out_ready;
    logic [1:0]   s_occupancy;
    logic [2:0]   s_stall;

    pipe_stage_skid dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy), .stall_cycles(stall_cycles)
    );

    pipe_stage_skid #(.STALL_CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_ctrl(24'h000123), .in_data(128'h55),
        .flush(1'b0),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
        .occupancy(s_occupancy), .stall_cycles(s_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0]  c;
        logic [127:0] d;
    } bundle_t;

    bundle_t      q[$];
    logic [127:0] main_data_m;
    logic [15:0]  exp_stall;
    int           n_cmp;
    int           n_err;

    function automatic logic [23:0] exp_ctrl();
        return (q.size() > 0) ? q[0].c : 24'h0;
    endfunction

    function automatic logic [1:0] exp_occ();
        return 2'(q.size());
    endfunction

    function automatic logic [127:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        q.delete();
        main_data_m = '0;
        exp_stall   = '0;
    endtask

    // Advance the reference model by one edge using the pre-edge inputs, then
    // move the simulation to just after that edge.
    task automatic step();
        bit      inf;
        bit      outf;
        bundle_t b;
        outf = (q.size() > 0) && out_ready;
        inf  = in_valid && (q.size() < 2);
        if ((q.size() > 0) && !out_ready && (exp_stall != 16'hFFFF)) exp_stall++;
        if (outf) $display("xfer out ctrl=%06h data=%032h%s", q[0].c, q[0].d, flush ? " (flush)" : "");
        if (flush) begin
            q.delete();
        end else begin
            if (outf) b = q.pop_front();
            if (inf) q.push_back({in_ctrl, in_data});
        end
        if (q.size() > 0) main_data_m = q[0].d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; flush = 1'b0; in_ctrl = '0; in_data = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle_inputs(); out_ready = 1'b0;
        s_in_valid = 1'b0; s_out_ready = 1'b0;
        #12;
        model_reset();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (out_ctrl !== 24'h0) begin n_err++; $display("FAIL reset_out_ctrl got=%h want=0", out_ctrl); end
        n_cmp++; if (out_data !== 128'h0) begin n_err++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL reset_occ got=%0d want=0", occupancy); end
        n_cmp++; if (stall_cycles !== 16'd0) begin n_err++; $display("FAIL reset_stall got=%0d want=0", stall_cycles); end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1; in_ctrl = 24'(i); in_data = rand_data();
            step();
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d] got=%b want=1", i, out_valid); end
            n_cmp++; if (out_ctrl !== 24'(i)) begin n_err++; $display("FAIL stream_ctrl[%0d] got=%h want=%h", i, out_ctrl, 24'(i)); end
            n_cmp++; if (out_data !== main_data_m) begin n_err++; $display("FAIL stream_data[%0d] got=%h want=%h", i, out_data, main_data_m); end
            n_cmp++; if (occupancy > 2'd1) begin n_err++; $display("FAIL stream_occ[%0d] got=%0d want<=1", i, occupancy); end
            n_cmp++; if (stall_cycles !== 16'd0) begin n_err++; $display("FAIL stream_stall[%0d] got=%0d want=0", i, stall_cycles); end
        end
        idle_inputs();
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [23:0] want [3];
        want[0] = 24'h0000A1; want[1] = 24'h0000B2; want[2] = 24'h0000C3;
        out_ready = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_a got=%b want=1", in_ready); end
        in_valid = 1'b1; in_ctrl = want[0]; in_data = rand_data(); step();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_b got=%b want=1", in_ready); end
        in_ctrl = want[1]; in_data = rand_data(); step();
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_full got=%b want=0", in_ready); end
        n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL bp_occ_full got=%0d want=2", occupancy); end
        in_ctrl = want[2]; in_data = rand_data();
        for (int k = 0; k < 2; k++) begin
            step();
            n_cmp++; if (occupancy !== 2'd2 || out_ctrl !== want[0]) begin
                n_err++; $display("FAIL bp_hold[%0d] got occ=%0d ctrl=%h want occ=2 ctrl=%h", k, occupancy, out_ctrl, want[0]);
            end
        end
        out_ready = 1'b1; step();
        n_cmp++; if (out_ctrl !== want[1]) begin n_err++; $display("FAIL bp_out_b got=%h want=%h", out_ctrl, want[1]); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_back got=%b want=1", in_ready); end
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_ctrl !== want[2]) begin n_err++; $display("FAIL bp_out_c got=%h want=%h", out_ctrl, want[2]); end
        n_cmp++; if (out_data !== main_data_m) begin n_err++; $display("FAIL bp_data_c got=%h want=%h", out_data, main_data_m); end
        step();
        n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            n_err++; $display("FAIL bp_empty got valid=%b occ=%0d want 0/0", out_valid, occupancy);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        in_ctrl = 24'h000011; in_data = rand_data(); step();
        in_ctrl = 24'h000022; in_data = rand_data(); step();
        in_ctrl = 24'h0000DD; in_data = rand_data(); flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got=%b want=0", out_valid); end
        n_cmp++; if (out_ctrl !== 24'h0) begin n_err++; $display("FAIL flush_ctrl got=%h want=0", out_ctrl); end
        n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL flush_occ got=%0d want=0", occupancy); end
        n_cmp++; if (out_data !== main_data_m) begin n_err++; $display("FAIL flush_data got=%h want=%h", out_data, main_data_m); end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_absent[%0d] got=%b want=0", k, out_valid); end
        end
    endtask

    task automatic test_bubble();
        logic [127:0] d;
        d = rand_data();
        out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 24'hABCDEF; in_data = d;
        step();
        idle_inputs();
        n_cmp++; if (out_ctrl !== 24'hABCDEF) begin n_err++; $display("FAIL bubble_ctrl_live got=%h want=abcdef", out_ctrl); end
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bubble_valid got=%b want=0", out_valid); end
        n_cmp++; if (out_ctrl !== 24'h0) begin n_err++; $display("FAIL bubble_ctrl got=%h want=0", out_ctrl); end
        n_cmp++; if (out_data !== d) begin n_err++; $display("FAIL bubble_data got=%h want=%h", out_data, d); end
    endtask

    task automatic test_async_reset();
        int guard;
        out_ready = 1'b0; in_valid = 1'b1;
        guard = 0;
        while ((exp_stall < 16'd7 || q.size() < 2) && guard < 20) begin
            in_ctrl = 24'($urandom); in_data = rand_data();
            step();
            guard++;
        end
        in_valid = 1'b0;
        n_cmp++; if (occupancy !== 2'd2 || stall_cycles !== 16'd7) begin
            n_err++; $display("FAIL areset_pre got occ=%0d stall=%0d want occ=2 stall=7", occupancy, stall_cycles);
        end
        #3 reset = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL areset_valid got=%b want=0", out_valid); end
        n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL areset_occ got=%0d want=0", occupancy); end
        n_cmp++; if (stall_cycles !== 16'd0) begin n_err++; $display("FAIL areset_stall got=%0d want=0", stall_cycles); end
        n_cmp++; if (out_ctrl !== 24'h0) begin n_err++; $display("FAIL areset_ctrl got=%h want=0", out_ctrl); end
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        logic [2:0] want;
        s_out_ready = 1'b0; s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        n_cmp++; if (s_out_valid !== 1'b1 || s_stall !== 3'd0) begin
            n_err++; $display("FAIL sat_start got valid=%b stall=%0d want 1/0", s_out_valid, s_stall);
        end
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            want = (k > 7) ? 3'd7 : 3'(k);
            n_cmp++; if (s_stall !== want) begin n_err++; $display("FAIL sat_count[%0d] got=%0d want=%0d", k, s_stall, want); end
        end
        s_out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (s_out_valid !== 1'b0 || s_stall !== 3'd7) begin
            n_err++; $display("FAIL sat_drain got valid=%b stall=%0d want 0/7", s_out_valid, s_stall);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_ctrl   = 24'($urandom);
            in_data   = rand_data();
            step();
            n_cmp++; if (out_valid !== (q.size() > 0)) begin n_err++; $display("FAIL rnd_valid[%0d] got=%b want=%b", i, out_valid, q.size() > 0); end
            n_cmp++; if (out_ctrl !== exp_ctrl()) begin n_err++; $display("FAIL rnd_ctrl[%0d] got=%h want=%h", i, out_ctrl, exp_ctrl()); end
            n_cmp++; if (out_data !== main_data_m) begin n_err++; $display("FAIL rnd_data[%0d] got=%h want=%h", i, out_data, main_data_m); end
            n_cmp++; if (occupancy !== exp_occ()) begin n_err++; $display("FAIL rnd_occ[%0d] got=%0d want=%0d", i, occupancy, exp_occ()); end
            n_cmp++; if (in_ready !== (q.size() < 2)) begin n_err++; $display("FAIL rnd_ready[%0d] got=%b want=%b", i, in_ready, q.size() < 2); end
            n_cmp++; if (stall_cycles !== exp_stall) begin n_err++; $display("FAIL rnd_stall[%0d] got=%0d want=%0d", i, stall_cycles, exp_stall); end
        end
        idle_inputs();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_bubble();
        test_async_reset();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised pipeline-stage register, the successor to the fixed-field decode/execute interface register. It carries a control bundle and a data bundle between any two pipeline stages using a valid/ready handshake and a 2-entry skid buffer, so backpressure is absorbed without a combinational ready path. It supports a synchronous flush for branch/exception squash and forces control to a bubble value whenever the stage is empty. A saturating stall counter is provided for performance debug.

Parameters:
CTRL_W, 24, width of control bundle (ALU op, write enables, register-write, etc.); zeroed on bubble.
DATA_W, 128, width of data bundle (operands, immediate, PC, register indices); not zeroed on bubble.
CTRL_BUBBLE, 0, CTRL_W-bit value driven on out_ctrl when out_valid=0.
STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  upstream has a valid bundle
in_ready  out  1  stage can accept; registered, equals !skid_valid
in_ctrl  in  CTRL_W  upstream control bundle
in_data  in  DATA_W  upstream data bundle
flush  in  1  synchronous squash of all held entries
out_valid  out  1  main entry valid
out_ready  in  1  downstream accepts
out_ctrl  out  CTRL_W  main control; CTRL_BUBBLE when !out_valid
out_data  out  DATA_W  main data; holds last value when !out_valid
occupancy  out  2  entries held: 0, 1 or 2
stall_cycles  out  STALL_CNT_W  count of cycles with out_valid && !out_ready

Behaviour:
- Reset (async, any time, including mid-transfer): out_valid=0, skid_valid=0, in_ready=1 after reset deasserts, out_ctrl=CTRL_BUBBLE, out_data=0, skid registers=0, occupancy=0, stall_cycles=0. No transfer is recorded on an edge while reset is high.
- in_fire = in_valid && in_ready; out_fire = out_valid && out_ready.
- States are encoded by {skid_valid, out_valid}:
  - EMPTY (00): in_fire -> ONE, main<=in.
  - ONE (01): in_fire && !out_fire -> FULL, skid<=in. in_fire && out_fire -> ONE, main<=in. !in_fire && out_fire -> EMPTY, main ctrl<=CTRL_BUBBLE. Neither -> hold.
  - FULL (11): in_ready=0, so no in_fire. out_fire -> ONE, main<=skid, skid_valid<=0. Otherwise hold.
- Latency: 1 cycle from in_fire to out_valid when the stage is empty. Sustained throughput is 1 bundle per cycle when out_ready=1.
- Data ordering is strictly FIFO. The skid entry is never bypassed around main.
- in_ready depends only on registers; there is no combinational path from out_ready to in_ready.
- flush has highest priority. On the next edge the state is EMPTY, main ctrl=CTRL_BUBBLE, and skid_valid=0. A same-cycle in_fire is discarded and a same-cycle out_fire still completes downstream. Data registers are not cleared by flush.
- Bubble rule: out_ctrl is driven from a register and is glitch-free. It equals CTRL_BUBBLE on every cycle where out_valid=0.
- While out_valid=1 && out_ready=0, main and skid contents must not change.
- stall_cycles increments by 1 on each edge where out_valid && !out_ready holds. It saturates at 2^STALL_CNT_W-1, is cleared only by reset, and is unaffected by flush.
- occupancy = out_valid + skid_valid.
- Upstream bundle contents are don't-care when in_valid=0. Upstream need not hold in_valid when in_ready=0 (a drop is allowed), but the stage never loses an accepted bundle.

Test Plan:
- Reset then stream: out_ready=1, feed ctrl=0x000001..0x000005 one per cycle -> out_valid rises 1 cycle after the first in_fire, values emerge in order at 1 per cycle, occupancy stays ≤1, stall_cycles=0.
- Backpressure fill: out_ready=0, offer A then B -> in_ready=1,1, then 0 with occupancy=2. Offer C held -> not accepted. Release out_ready -> outputs A, B, C in order, and in_ready returns to 1 the cycle after A leaves.
- Flush in FULL with simultaneous in_valid=1 and out_ready=0 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, and the offered bundle is absent from the output.
- Bubble: single bundle ctrl=0xABCDEF accepted and drained -> on the cycle after the drain, out_valid=0 and out_ctrl=0x000000 while out_data still shows the last data.
- Async reset mid-stall, asserted between edges with occupancy=2 and stall_cycles=7 -> immediately out_valid=0, occupancy=0, stall_cycles=0, out_ctrl=0.
- Counter saturation with STALL_CNT_W=3: hold a stall for 10 cycles -> stall_cycles reads 1..7 and then stays at 7.
